// File: rtl/tick_scheduler_pkg.sv
// Shared types for the tick scheduler: command, mode and FSM state encodings.
package tick_scheduler_pkg;

    typedef enum logic [1:0] {
        NOP    = 2'd0,
        START  = 2'd1,
        STOP   = 2'd2,
        UPDATE = 2'd3
    } cmd_e;

    typedef enum logic {
        PERIODIC = 1'b0,
        ONESHOT  = 1'b1
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_e;

    typedef enum logic {
        ACCEPT = 1'b0,
        COMMIT = 1'b1
    } ctrl_state_e;

    // Index width that stays at least one bit wide for single-entry ranges.
    function automatic int chWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_scheduler_channel.sv
// One tick channel: IDLE/RUN FSM with a free-running counter, active period and shadow period.
module tick_scheduler_channel
    import tick_scheduler_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             en_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             update_i,
    input  logic [WIDTH-1:0] period_i,
    input  logic             mode_i,
    output logic             tick_o,
    output logic             busy_o,
    output logic             done_o
);

    ch_state_e        state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            mode_q   <= PERIODIC;
            cnt_q    <= '0;
            period_q <= '0;
            shadow_q <= '0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            shadow_q <= shadow_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
        end
    end

    // Commands take priority over counting, so a STOP swallows a tick due on the same edge.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        shadow_d = shadow_q;
        tick_d   = 1'b0;
        done_d   = 1'b0;
        if (start_i) begin
            state_d  = RUN;
            mode_d   = mode_e'(mode_i);
            cnt_d    = '0;
            period_d = period_i;
            shadow_d = period_i;
        end else if (stop_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            if (update_i) begin
                shadow_d = period_i;
                if (state_q == IDLE) begin
                    period_d = period_i;
                end
            end
            if (state_q == RUN && en_i) begin
                if (cnt_q == period_q - WIDTH'(1)) begin
                    cnt_d    = '0;
                    period_d = shadow_d;
                    tick_d   = 1'b1;
                    if (mode_q == ONESHOT) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
        end
    end

    assign tick_o = tick_q;
    assign done_o = done_q;
    assign busy_o = (state_q == RUN);

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel tick scheduler: config FSM, command decode and NUM_CH channels.
// Define TICK_SCHEDULER_PRESCALE_EN to advance channels only on a shared PRESCALE-cycle enable.
module tick_scheduler
    import tick_scheduler_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int WIDTH    = 32,
    parameter int PRESCALE = 8
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       cfg_valid_i,
    output logic                       cfg_ready_o,
    input  logic [chWidth(NUM_CH)-1:0] cfg_ch_i,
    input  logic [1:0]                 cfg_cmd_i,
    input  logic [WIDTH-1:0]           cfg_period_i,
    input  logic                       cfg_mode_i,
    output logic [NUM_CH-1:0]          tick_o,
    output logic [NUM_CH-1:0]          busy_o,
    output logic [NUM_CH-1:0]          done_o
);

    localparam int CH_W = chWidth(NUM_CH);

    ctrl_state_e      ctrlState_q, ctrlState_d;
    logic             ready_q, ready_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    cmd_e             cmd_q, cmd_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             mode_q, mode_d;
    logic             commit;
    logic             en;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ctrlState_q <= ACCEPT;
            ready_q     <= 1'b0;
            ch_q        <= '0;
            cmd_q       <= NOP;
            period_q    <= '0;
            mode_q      <= 1'b0;
        end else begin
            ctrlState_q <= ctrlState_d;
            ready_q     <= ready_d;
            ch_q        <= ch_d;
            cmd_q       <= cmd_d;
            period_q    <= period_d;
            mode_q      <= mode_d;
        end
    end

    // Ready is registered so it stays low through reset and rises one edge after release.
    always_comb begin
        ctrlState_d = ctrlState_q;
        ch_d        = ch_q;
        cmd_d       = cmd_q;
        period_d    = period_q;
        mode_d      = mode_q;
        commit      = 1'b0;
        case (ctrlState_q)
            ACCEPT: begin
                if (cfg_valid_i && ready_q) begin
                    ctrlState_d = COMMIT;
                    ch_d        = cfg_ch_i;
                    cmd_d       = cmd_e'(cfg_cmd_i);
                    period_d    = (cfg_period_i == '0) ? WIDTH'(1) : cfg_period_i;
                    mode_d      = cfg_mode_i;
                end
            end
            COMMIT: begin
                commit      = 1'b1;
                ctrlState_d = ACCEPT;
            end
            default: ctrlState_d = ACCEPT;
        endcase
        ready_d = (ctrlState_d == ACCEPT);
    end

    assign cfg_ready_o = ready_q;

`ifdef TICK_SCHEDULER_PRESCALE_EN
    localparam int PW = chWidth(PRESCALE);

    logic [PW-1:0] presc_q;
    logic          presc_en_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            presc_q    <= '0;
            presc_en_q <= 1'b0;
        end else begin
            presc_q    <= (presc_q == PW'(PRESCALE - 1)) ? '0 : presc_q + PW'(1);
            presc_en_q <= (presc_q == PW'(PRESCALE - 1));
        end
    end

    assign en = presc_en_q;
`else
    assign en = 1'b1;
`endif

    // Out-of-range channel indices match no instance, so such commands are dropped here.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic sel;
        assign sel = commit && (ch_q == CH_W'(g));

        tick_scheduler_channel #(
            .WIDTH(WIDTH)
        ) u_channel (
            .clk_i   (clk_i),
            .rstn_i  (rstn_i),
            .en_i    (en),
            .start_i (sel && (cmd_q == START)),
            .stop_i  (sel && (cmd_q == STOP)),
            .update_i(sel && (cmd_q == UPDATE)),
            .period_i(period_q),
            .mode_i  (mode_q),
            .tick_o  (tick_o[g]),
            .busy_o  (busy_o[g]),
            .done_o  (done_o[g])
        );
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed self-checking bench for tick_scheduler in its default (no prescaler) build.
module tb_tick_scheduler;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 32;

    logic              clk_i;
    logic              rstn_i;
    logic              cfg_valid_i;
    logic              cfg_ready_o;
    logic [1:0]        cfg_ch_i;
    logic [1:0]        cfg_cmd_i;
    logic [WIDTH-1:0]  cfg_period_i;
    logic              cfg_mode_i;
    logic [NUM_CH-1:0] tick_o;
    logic [NUM_CH-1:0] busy_o;
    logic [NUM_CH-1:0] done_o;

    int assertCount = 0;
    int failCount   = 0;

    tick_scheduler #(
        .NUM_CH  (NUM_CH),
        .WIDTH   (WIDTH),
        .PRESCALE(8)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_ch_i    (cfg_ch_i),
        .cfg_cmd_i   (cfg_cmd_i),
        .cfg_period_i(cfg_period_i),
        .cfg_mode_i  (cfg_mode_i),
        .tick_o      (tick_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the accepting edge ("edge 0").
    task automatic applyStimulus(input logic [1:0] ch, input logic [1:0] cmd,
                                 input logic [31:0] period, input logic mode);
        int waited = 0;
        while (!cfg_ready_o && waited < 20) begin
            @(negedge clk_i);
            waited++;
        end
        if (!cfg_ready_o) checkOutput("readyTimeout", 32'(cfg_ready_o), 32'd1);
        cfg_ch_i     = ch;
        cfg_cmd_i    = cmd;
        cfg_period_i = period;
        cfg_mode_i   = mode;
        cfg_valid_i  = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        cfg_valid_i  = 1'b0;
        cfg_cmd_i    = 2'd0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        rstn_i       = 1'b0;
        cfg_valid_i  = 1'b0;
        cfg_ch_i     = '0;
        cfg_cmd_i    = '0;
        cfg_period_i = '0;
        cfg_mode_i   = 1'b0;

        #22;
        checkOutput("rstReady", 32'(cfg_ready_o), 32'd0);
        checkOutput("rstTick",  32'(tick_o), 32'd0);
        checkOutput("rstBusy",  32'(busy_o), 32'd0);
        checkOutput("rstDone",  32'(done_o), 32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        waitCycles(1);
        checkOutput("readyAfterRst", 32'(cfg_ready_o), 32'd1);

        // START ch0, P=4 periodic: ticks after edges 5, 9, 13.
        applyStimulus(2'd0, 2'd1, 32'd4, 1'b0);
        checkOutput("t1ReadyLow", 32'(cfg_ready_o), 32'd0);
        checkOutput("t1TickE0", 32'(tick_o[0]), 32'd0);
        for (int k = 1; k <= 13; k++) begin
            waitCycles(1);
            checkOutput($sformatf("t1Tick%0d", k), 32'(tick_o[0]),
                        32'((k == 5) || (k == 9) || (k == 13)));
            if (k == 1) checkOutput("t1ReadyBack", 32'(cfg_ready_o), 32'd1);
        end
        checkOutput("t1Busy", 32'(busy_o[0]), 32'd1);

        // START ch1, P=3 one-shot: single tick+done after edge 4, busy drops there.
        applyStimulus(2'd1, 2'd1, 32'd3, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            waitCycles(1);
            checkOutput($sformatf("t2Tick%0d", k), 32'(tick_o[1]), 32'(k == 4));
            checkOutput($sformatf("t2Done%0d", k), 32'(done_o[1]), 32'(k == 4));
            checkOutput($sformatf("t2Busy%0d", k), 32'(busy_o[1]), 32'((k >= 1) && (k < 4)));
        end

        // NOP to ch2 has no effect.
        applyStimulus(2'd2, 2'd0, 32'd5, 1'b0);
        waitCycles(2);
        checkOutput("nopBusy", 32'(busy_o[2]), 32'd0);

        // Restart ch0 P=4, UPDATE to 2 committed at edge 4: ticks at 5, then 7, 9, 11, 13.
        applyStimulus(2'd0, 2'd1, 32'd4, 1'b0);
        waitCycles(2);
        applyStimulus(2'd0, 2'd3, 32'd2, 1'b0);
        for (int k = 4; k <= 12; k++) begin
            waitCycles(1);
            checkOutput($sformatf("t3Tick%0d", k), 32'(tick_o[0]),
                        32'((k == 5) || (k == 7) || (k == 9) || (k == 11)));
        end
        waitCycles(1);
        checkOutput("t3Tick13", 32'(tick_o[0]), 32'd1);

        // STOP committed at edge 15 where a tick is due: suppressed.
        applyStimulus(2'd0, 2'd2, 32'd0, 1'b0);
        checkOutput("t4Tick14", 32'(tick_o[0]), 32'd0);
        for (int k = 15; k <= 18; k++) begin
            waitCycles(1);
            checkOutput($sformatf("t4Tick%0d", k), 32'(tick_o[0]), 32'd0);
            checkOutput($sformatf("t4Busy%0d", k), 32'(busy_o[0]), 32'd0);
        end

        // START P=0 clamps to 1: tick every cycle from edge 2.
        applyStimulus(2'd0, 2'd1, 32'd0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            waitCycles(1);
            checkOutput($sformatf("t4bTick%0d", k), 32'(tick_o[0]), 32'(k >= 2));
        end

        // Asynchronous reset between edges clears outputs immediately.
        #2;
        rstn_i = 1'b0;
        #1;
        checkOutput("t5Tick", 32'(tick_o), 32'd0);
        checkOutput("t5Busy", 32'(busy_o), 32'd0);
        checkOutput("t5Done", 32'(done_o), 32'd0);
        checkOutput("t5Ready", 32'(cfg_ready_o), 32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            waitCycles(1);
            checkOutput($sformatf("t5PostTick%0d", k), 32'(tick_o), 32'd0);
            checkOutput($sformatf("t5PostBusy%0d", k), 32'(busy_o), 32'd0);
        end
        checkOutput("t5PostReady", 32'(cfg_ready_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL globalTimeout: got 0 expected 1");
        $fatal(1, "[TB] timeout");
    end

endmodule
